ag32gbd_tile_pack: RTL

Writer side of the 2bpp tile output buffer in block RAM. The bram read path drains this buffer into cartridge RAM.
- Accepts raster-order 2-bit camera pixels.
- Packs each 8-pixel row segment into Game Boy 2bpp plane bytes.
- Writes the plane bytes into ping-pong strip buffers A (0x000-0x0FF) and B (0x100-0x1FF).
- Hands each completed 8-line strip to the consumer with a done/release handshake.

---
 rtl/ag32gbd_tile_pack.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ag32gbd_tile_pack.sv
// ag32gbd_tile_pack
// Writer side of the 2bpp tile strip buffer. Packs raster-order 2-bit pixels
// into Game Boy plane bytes and writes them into ping-pong strip buffers
// A (0x000-0x0FF) and B (0x100-0x1FF), handing each finished 8-line strip to
// the consumer with a done/release handshake.
//
// Ports:
//   sys_clock, sys_resetn          clock, async active-low reset
//   Frame_Start                    restart packing at pixel (0,0)
//   Pixel_Valid/Pixel_Data         pixel input (0 = white, 3 = black)
//   Pixel_Ready                    combinational accept qualifier
//   RequestWriteBuffer             one-cycle bram write strobe
//   BufferWriteOffset/Data         bram byte offset and plane byte
//   Strip_Done/Strip_Buffer        strip complete / oldest full buffer
//   Strip_Release                  consumer frees the oldest full buffer
//   Frame_Done                     pulses with the final Strip_Done of a frame
module ag32gbd_tile_pack #(
    parameter int unsigned IMG_WIDTH   = 128,
    parameter int unsigned IMG_HEIGHT  = 112,
    parameter logic [9:0]  BASE_OFFSET = 10'h000
) (
    input  logic       sys_clock,
    input  logic       sys_resetn,
    input  logic       Frame_Start,
    input  logic       Pixel_Valid,
    input  logic [1:0] Pixel_Data,
    output logic       Pixel_Ready,
    output logic       RequestWriteBuffer,
    output logic [9:0] BufferWriteOffset,
    output logic [7:0] BufferWriteData,
    output logic       Strip_Done,
    output logic       Strip_Buffer,
    input  logic       Strip_Release,
    output logic       Frame_Done
);

    localparam int unsigned XW = 7;
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    hold_hi_q, hold_hi_d;
    logic          hold_sel_q, hold_sel_d;
    logic          hold_last_strip_q, hold_last_strip_d;
    logic          hold_last_frame_q, hold_last_frame_d;
    logic [1:0]    full_q, full_d;
    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic          req_q, req_d;
    logic [9:0]    offset_q, offset_d;
    logic [7:0]    data_q, data_d;
    logic          strip_done_q, strip_done_d;
    logic          frame_done_q, frame_done_d;

    logic          ready;
    logic          accept;
    logic [7:0]    lo_nx;
    logic [7:0]    hi_nx;
    logic          x_last;
    logic          y_last;

    // Frame_Start has priority over a simultaneous pixel.
    assign ready  = !full_q[wr_sel_q] && !Frame_Start;
    assign accept = Pixel_Valid && ready;
    assign lo_nx  = {lo_q[6:0], Pixel_Data[0]};
    assign hi_nx  = {hi_q[6:0], Pixel_Data[1]};
    assign x_last = (x_q == XW'(IMG_WIDTH - 1));
    assign y_last = (y_q == YW'(IMG_HEIGHT - 1));

    // Next-state: packing, write sequencing, strip hand-off.
    always_comb begin
        state_d           = state_q;
        x_d               = x_q;
        y_d               = y_q;
        lo_d              = lo_q;
        hi_d              = hi_q;
        hold_hi_d         = hold_hi_q;
        hold_sel_d        = hold_sel_q;
        hold_last_strip_d = hold_last_strip_q;
        hold_last_frame_d = hold_last_frame_q;
        full_d            = full_q;
        wr_sel_d          = wr_sel_q;
        rd_sel_d          = rd_sel_q;
        req_d             = 1'b0;
        offset_d          = offset_q;
        data_d            = data_q;
        strip_done_d      = 1'b0;
        frame_done_d      = 1'b0;

        // A pending plane write or strip completion is abandoned by Frame_Start.
        if (!Frame_Start) begin
            case (state_q)
                IDLE: begin
                end
                WR_LO: begin
                    // Plane-1 byte lands one address above the plane-0 byte.
                    req_d    = 1'b1;
                    data_d   = hold_hi_q;
                    offset_d = offset_q + 10'd1;
                    state_d  = WR_HI;
                end
                WR_HI: begin
                    state_d = IDLE;
                    if (hold_last_strip_q) begin
                        full_d[hold_sel_q] = 1'b1;
                        strip_done_d       = 1'b1;
                        wr_sel_d           = ~hold_sel_q;
                        frame_done_d       = hold_last_frame_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Oldest full buffer is freed; release with nothing full is a no-op.
        if (Strip_Release && full_q[rd_sel_q]) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = ~rd_sel_q;
        end

        if (accept) begin
            lo_d = lo_nx;
            hi_d = hi_nx;
            if (x_last) begin
                x_d = '0;
                y_d = y_last ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
            // Eighth pixel of a segment: issue plane 0 next cycle, hold plane 1.
            if (x_q[2:0] == 3'd7) begin
                req_d             = 1'b1;
                data_d            = lo_nx;
                offset_d          = BASE_OFFSET + 10'({wr_sel_q, x_q[6:3], y_q[2:0], 1'b0});
                hold_hi_d         = hi_nx;
                hold_sel_d        = wr_sel_q;
                hold_last_strip_d = (y_q[2:0] == 3'd7) && x_last;
                hold_last_frame_d = (y_q[2:0] == 3'd7) && x_last && y_last;
                state_d           = WR_LO;
            end
        end

        if (Frame_Start) begin
            x_d     = '0;
            y_d     = '0;
            lo_d    = '0;
            hi_d    = '0;
            state_d = IDLE;
        end
    end

    // State and output registers.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q           <= IDLE;
            x_q               <= '0;
            y_q               <= '0;
            lo_q              <= '0;
            hi_q              <= '0;
            hold_hi_q         <= '0;
            hold_sel_q        <= 1'b0;
            hold_last_strip_q <= 1'b0;
            hold_last_frame_q <= 1'b0;
            full_q            <= '0;
            wr_sel_q          <= 1'b0;
            rd_sel_q          <= 1'b0;
            req_q             <= 1'b0;
            offset_q          <= '0;
            data_q            <= '0;
            strip_done_q      <= 1'b0;
            frame_done_q      <= 1'b0;
        end else begin
            state_q           <= state_d;
            x_q               <= x_d;
            y_q               <= y_d;
            lo_q              <= lo_d;
            hi_q              <= hi_d;
            hold_hi_q         <= hold_hi_d;
            hold_sel_q        <= hold_sel_d;
            hold_last_strip_q <= hold_last_strip_d;
            hold_last_frame_q <= hold_last_frame_d;
            full_q            <= full_d;
            wr_sel_q          <= wr_sel_d;
            rd_sel_q          <= rd_sel_d;
            req_q             <= req_d;
            offset_q          <= offset_d;
            data_q            <= data_d;
            strip_done_q      <= strip_done_d;
            frame_done_q      <= frame_done_d;
        end
    end

    assign Pixel_Ready        = ready;
    assign RequestWriteBuffer = req_q;
    assign BufferWriteOffset  = offset_q;
    assign BufferWriteData    = data_q;
    assign Strip_Done         = strip_done_q;
    assign Strip_Buffer       = rd_sel_q;
    assign Frame_Done         = frame_done_q;

endmodule
